// File: rtl/frankie_mem_arbiter.sv
// Two-port (processor / loader) arbiter in front of a single-port synchronous-read memory.
// Each access walks IDLE -> ISSUE -> WAIT -> ACK; conflicts alternate between the ports.
module frankie_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_rdata,
    input  logic              ld_hold,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t            state;
    state_t            state_next;
    logic              last_grant;
    logic              winner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              cpu_ok;
    logic              any_req;
    logic              pick_ld;

    // last_grant / winner encoding: 1 = loader, 0 = processor
    assign cpu_ok  = cpu_req & ~ld_hold;
    assign any_req = cpu_ok | ld_req;
    assign pick_ld = (cpu_ok && ld_req) ? ~last_grant : ld_req;

    assign cpu_stall = cpu_req & ~cpu_ack;

    always_comb begin
        state_next = state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_ack    = 1'b0;
        ld_ack     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
                mem_en     = 1'b1;
                mem_we     = lat_we;
                mem_addr   = lat_addr;
                mem_wdata  = lat_wdata;
            end
            WAIT: begin
                state_next = ACK;
            end
            ACK: begin
                state_next = IDLE;
                cpu_ack    = ~winner;
                ld_ack     = winner;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Winner fields are captured once in IDLE so requesters may drop req during ACK.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            winner     <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cpu_rdata  <= '0;
            ld_rdata   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) begin
                winner     <= pick_ld;
                last_grant <= pick_ld;
                lat_we     <= pick_ld ? ld_we    : cpu_we;
                lat_addr   <= pick_ld ? ld_addr  : cpu_addr;
                lat_wdata  <= pick_ld ? ld_wdata : cpu_wdata;
            end
            if (state == WAIT && !lat_we) begin
                if (winner) begin
                    ld_rdata <= mem_rdata;
                end else begin
                    cpu_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule
